controlador_execucao: RTL and testbench

Execution sequencer for the single-cycle processor. It gates instruction commit (PC update, register-bank and data-memory writes) through a cycle enable and stalls the core on IN, OUT and HALT. It debounces the board pushbutton and uses each press to release a stall. It latches switch input for IN and the display value for OUT. It sits between the control unit's In/Out/Halt decodes and the input/output modules, and replaces the free-running clock-enable path.

---
 rtl/controlador_execucao.sv | 141 ++++++++++++++
 tb/tb_controlador_execucao.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_execucao.sv
// Execution sequencer: gates commit via HabilitaCPU, stalls on IN/OUT/HALT, releases a stall on a debounced button press.
// Optional single-step mode under PASSO_A_PASSO_EN (each press commits one ordinary instruction).
module controlador_execucao #(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int LARGURA_SW      = 14
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Botao,
  input  logic [LARGURA_SW-1:0] Sw,
  input  logic                  In,
  input  logic                  Out,
  input  logic                  Halt,
  input  logic [31:0]           DadoSaida,
  output logic                  HabilitaCPU,
  output logic [31:0]           DadoEntrada,
  output logic                  EntradaValida,
  output logic [31:0]           RegistroSaida,
  output logic [2:0]            Estado,
  output logic                  Aguardando
);

  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [2:0] {
    EXECUTA        = 3'b000,
    ESPERA_ENTRADA = 3'b001,
    ESPERA_SAIDA   = 3'b010,
    PARADO         = 3'b011,
    CONFIRMA       = 3'b100
  } estado_t;

  logic [1:0]    sinc_q;
  logic          botao_sinc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          deb_ant_q;
  logic          pressao;

  estado_t       estado_q;
  logic [31:0]   dado_entrada_q;
  logic [31:0]   registro_saida_q;
  logic          conf_entrada_q;
  logic          libera_execucao;
  logic          instr_comum;

  // Synchronizer idles high so a released button never looks like a press out of reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sinc_q <= 2'b11;
    end else begin
      sinc_q <= {sinc_q[0], Botao};
    end
  end

  assign botao_sinc = sinc_q[1];

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (botao_sinc == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = botao_sinc;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q     <= '0;
      deb_q     <= 1'b1;
      deb_ant_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_ant_q <= deb_q;
    end
  end

  // One pulse per debounced falling edge; holding the button yields no further pulses.
  assign pressao = deb_ant_q & ~deb_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_q         <= EXECUTA;
      dado_entrada_q   <= '0;
      registro_saida_q <= '0;
      conf_entrada_q   <= 1'b0;
    end else begin
      case (estado_q)
        EXECUTA: begin
          if (Halt) begin
            estado_q <= PARADO;
          end else if (In) begin
            estado_q <= ESPERA_ENTRADA;
          end else if (Out) begin
            registro_saida_q <= DadoSaida;
            estado_q         <= ESPERA_SAIDA;
          end
        end
        ESPERA_ENTRADA: begin
          if (pressao) begin
            dado_entrada_q <= 32'(Sw);
            conf_entrada_q <= 1'b1;
            estado_q       <= CONFIRMA;
          end
        end
        ESPERA_SAIDA: begin
          if (pressao) begin
            conf_entrada_q <= 1'b0;
            estado_q       <= CONFIRMA;
          end
        end
        CONFIRMA: estado_q <= EXECUTA;
        PARADO:   estado_q <= PARADO;
        default:  estado_q <= EXECUTA;
      endcase
    end
  end

`ifdef PASSO_A_PASSO_EN
  assign libera_execucao = pressao;
`else
  assign libera_execucao = 1'b1;
`endif

  assign instr_comum   = ~In & ~Out & ~Halt;
  // A stalled instruction commits only in CONFIRMA, never on stall entry.
  assign HabilitaCPU   = ((estado_q == EXECUTA) & libera_execucao & instr_comum)
                       | (estado_q == CONFIRMA);
  assign EntradaValida = (estado_q == CONFIRMA) & conf_entrada_q;
  assign Aguardando    = (estado_q == ESPERA_ENTRADA) | (estado_q == ESPERA_SAIDA);
  assign Estado        = estado_q;
  assign DadoEntrada   = dado_entrada_q;
  assign RegistroSaida = registro_saida_q;

endmodule

// File: tb/tb_controlador_execucao.sv
// Directed bench for controlador_execucao with DEBOUNCE_CICLOS = 4.
module tb_controlador_execucao;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Botao;
  logic [13:0] Sw;
  logic        In, Out, Halt;
  logic [31:0] DadoSaida;
  logic        HabilitaCPU;
  logic [31:0] DadoEntrada;
  logic        EntradaValida;
  logic [31:0] RegistroSaida;
  logic [2:0]  Estado;
  logic        Aguardando;

  int n_cmp = 0;
  int n_err = 0;

  controlador_execucao #(.DEBOUNCE_CICLOS(4), .LARGURA_SW(14)) dut (
    .Clock(Clock), .Reset(Reset), .Botao(Botao), .Sw(Sw),
    .In(In), .Out(Out), .Halt(Halt), .DadoSaida(DadoSaida),
    .HabilitaCPU(HabilitaCPU), .DadoEntrada(DadoEntrada),
    .EntradaValida(EntradaValida), .RegistroSaida(RegistroSaida),
    .Estado(Estado), .Aguardando(Aguardando)
  );

  always #5 Clock = ~Clock;

  task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    n_cmp++;
    if (obtido !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obtido, esperado);
    end
  endtask

  // Advance one edge; samples taken 2 time units after the edge.
  task automatic ciclo();
    @(posedge Clock);
    #2;
  endtask

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  task automatic reinicia();
    Reset = 1'b0;
    ciclos(2);
    Reset = 1'b1;
    ciclo();
  endtask

  // Press for 10 cycles; report first HabilitaCPU cycle and sample state around it.
  task automatic pressiona_e_libera(output int primeiro, output int zeros_antes,
                                    output logic ev, output logic [31:0] de,
                                    output logic [2:0] est_commit, output logic [2:0] est_depois);
    primeiro = 0; zeros_antes = 0; ev = 1'b0; de = '0; est_commit = '1; est_depois = '1;
    Botao = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      ciclo();
      if (primeiro == 0) begin
        if (HabilitaCPU) begin
          primeiro   = i;
          ev         = EntradaValida;
          de         = DadoEntrada;
          est_commit = Estado;
          In = 1'b0;
          Out = 1'b0;
        end else begin
          zeros_antes++;
        end
      end else if (i == primeiro + 1) begin
        est_depois = Estado;
      end
    end
    Botao = 1'b1;
    ciclos(8);
  endtask

  int          prim, zer, uns;
  logic        ev;
  logic [31:0] de;
  logic [2:0]  e_c, e_d;

  initial begin
    Reset = 1'b0; Botao = 1'b0; Sw = '0; In = 0; Out = 0; Halt = 0; DadoSaida = '0;
    ciclos(3);
    verifica("rst_estado", {29'b0, Estado}, 32'h0);
    verifica("rst_regsaida", RegistroSaida, 32'h0);
    verifica("rst_dadoentrada", DadoEntrada, 32'h0);
    verifica("rst_aguardando", {31'b0, Aguardando}, 32'h0);
    verifica("rst_entvalida", {31'b0, EntradaValida}, 32'h0);
    Botao = 1'b1;
    Reset = 1'b1;
    uns = 0;
    for (int i = 0; i < 10; i++) begin
      ciclo();
      if (HabilitaCPU) uns++;
    end
`ifdef PASSO_A_PASSO_EN
    verifica("pos_rst_hab_sem_pressao", uns, 0);
    for (int k = 0; k < 3; k++) begin
      Botao = 1'b0;
      for (int i = 0; i < 8; i++) begin ciclo(); if (HabilitaCPU) uns++; end
      Botao = 1'b1;
      for (int i = 0; i < 8; i++) begin ciclo(); if (HabilitaCPU) uns++; end
    end
    verifica("passo_tres_pulsos", uns, 3);
`else
    verifica("pos_rst_hab_livre", uns, 10);
`endif

    // IN: stall entry, Sw changes while waiting, one commit on press
    @(posedge Clock); #1;
    In = 1'b1; Sw = 14'h3FFF;
    #1;
    verifica("in_hab_mesmo_ciclo", {31'b0, HabilitaCPU}, 32'h0);
    ciclo();
    verifica("in_estado", {29'b0, Estado}, 32'h1);
    verifica("in_aguardando", {31'b0, Aguardando}, 32'h1);
    ciclos(3);
    Sw = 14'h2A5;
    ciclos(2);
    verifica("in_sem_pressao_espera", {29'b0, Estado}, 32'h1);
    pressiona_e_libera(prim, zer, ev, de, e_c, e_d);
    verifica("in_latencia_commit", prim, 7);
    verifica("in_zeros_antes", zer, 6);
    verifica("in_estado_commit", {29'b0, e_c}, 32'h4);
    verifica("in_entvalida", {31'b0, ev}, 32'h1);
    verifica("in_dadoentrada", de, 32'h000002A5);
    verifica("in_volta_executa", {29'b0, e_d}, 32'h0);
    Sw = 14'h0F0;
    ciclo();
    verifica("in_dado_retido", DadoEntrada, 32'h000002A5);

    // OUT: latch at entry, held after commit
    @(posedge Clock); #1;
    Out = 1'b1; DadoSaida = 32'h1234;
    #1;
    verifica("out_hab_mesmo_ciclo", {31'b0, HabilitaCPU}, 32'h0);
    ciclo();
    DadoSaida = 32'hDEAD;
    verifica("out_regsaida", RegistroSaida, 32'h1234);
    verifica("out_estado", {29'b0, Estado}, 32'h2);
    pressiona_e_libera(prim, zer, ev, de, e_c, e_d);
    verifica("out_latencia_commit", prim, 7);
    verifica("out_entvalida_zero", {31'b0, ev}, 32'h0);
    verifica("out_volta_executa", {29'b0, e_d}, 32'h0);
    DadoSaida = 32'hBEEF;
    ciclos(2);
    verifica("out_regsaida_retido", RegistroSaida, 32'h1234);

    // Bounce: short lows never release the wait
    @(posedge Clock); #1;
    In = 1'b1;
    ciclo();
    for (int k = 0; k < 4; k++) begin
      Botao = 1'b0; ciclos(2);
      Botao = 1'b1; ciclos(2);
    end
    uns = 0;
    for (int i = 0; i < 10; i++) begin ciclo(); if (HabilitaCPU) uns++; end
    verifica("bounce_sem_liberacao", uns, 0);
    verifica("bounce_estado", {29'b0, Estado}, 32'h1);

    // Asynchronous reset in the middle of a wait
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    verifica("rst_meio_estado", {29'b0, Estado}, 32'h0);
    verifica("rst_meio_dadoentrada", DadoEntrada, 32'h0);
    verifica("rst_meio_regsaida", RegistroSaida, 32'h0);
    verifica("rst_meio_aguardando", {31'b0, Aguardando}, 32'h0);
    In = 1'b0;
    ciclo();
    Reset = 1'b1;
    ciclo();

    // Press held across wait entry: neither old nor held press releases
    Botao = 1'b0;
    ciclos(10);
    In = 1'b1;
    ciclos(10);
    verifica("pendente_nao_libera", {29'b0, Estado}, 32'h1);
    Botao = 1'b1;
    ciclos(10);
    verifica("soltar_nao_libera", {29'b0, Estado}, 32'h1);
    In = 1'b0;
    reinicia();

    // Halt has priority over In and is terminal
    @(posedge Clock); #1;
    Halt = 1'b1; In = 1'b1;
    #1;
    verifica("halt_hab_mesmo_ciclo", {31'b0, HabilitaCPU}, 32'h0);
    ciclo();
    verifica("halt_estado", {29'b0, Estado}, 32'h3);
    Halt = 1'b0; In = 1'b0;
    uns = 0;
    for (int k = 0; k < 2; k++) begin
      Botao = 1'b0;
      for (int i = 0; i < 10; i++) begin ciclo(); if (HabilitaCPU) uns++; end
      Botao = 1'b1;
      for (int i = 0; i < 10; i++) begin ciclo(); if (HabilitaCPU) uns++; end
    end
    verifica("halt_hab_zero", uns, 0);
    verifica("halt_terminal", {29'b0, Estado}, 32'h3);
    reinicia();
    verifica("halt_sai_com_reset", {29'b0, Estado}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
